// File: rtl/sdadc_multi.sv
// Multi-channel sigma-delta ADC back end: per-channel 1-bit feedback, shared window
// timing, window decimation, frame averaging and a banked result stream.
module sdadc_multi #(
    parameter int NUM_CH         = 2,
    parameter int ADC_WIDTH      = 8,
    parameter int LPF_DEPTH_BITS = 3
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 enable,
    input  logic [1:0]           osr_sel,
    input  logic [NUM_CH-1:0]    analog_cmp,
    output logic [NUM_CH-1:0]    analog_out,
    output logic [ADC_WIDTH-1:0] dout_data,
    output logic [2:0]           dout_ch,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 overrun,
    input  logic                 ovr_clr
);
    localparam int W   = ADC_WIDTH;
    localparam int L   = LPF_DEPTH_BITS;
    localparam int CW  = W + 3;
    localparam int SW  = W + 3;
    localparam int AW  = W + L;
    localparam int MAX = (1 << W) - 1;

    // Handshake: a result transfers on every rising edge where dout_valid && dout_ready;
    // dout_data/dout_ch hold while dout_valid && !dout_ready. The FSM state is dout_valid.
    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    logic [NUM_CH-1:0] delta_q;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     win_last;
    logic [1:0]        osr_q;
    logic [L-1:0]      frame_q;
    logic [SW-1:0]     sigma_q  [NUM_CH];
    logic [AW-1:0]     sum_q    [NUM_CH];
    logic [W-1:0]      bank_q   [NUM_CH];
    logic [SW:0]       win_sum  [NUM_CH];
    logic [SW:0]       win_shr  [NUM_CH];
    logic [W-1:0]      win_res  [NUM_CH];
    logic [AW-1:0]     avg_full [NUM_CH];
    logic [W-1:0]      avg      [NUM_CH];
    logic              win_end;
    logic              frame_end;

    state_t            state_q, state_d;
    logic [2:0]        ch_q, ch_d;
    logic              overrun_q, overrun_d;
    logic              hs, last_hs;

    // osr_q is refreshed at counter 0, so it is only trusted from count 1 onward;
    // the shortest window is 2^W cycles so count 0 can never be an end cycle.
    always_comb begin
        win_last  = CW'((32'd1 << (W + 32'(osr_q))) - 32'd1);
        win_end   = enable && (cnt_q == win_last);
        frame_end = win_end && (frame_q == {L{1'b1}});
    end

    // The end-cycle delta is folded in here rather than into sigma, which keeps sigma
    // within W+3 bits even for a full 2^(W+3)-cycle window of ones.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            win_sum[c]  = {1'b0, sigma_q[c]} + (SW+1)'(delta_q[c]);
            win_shr[c]  = win_sum[c] >> osr_q;
            win_res[c]  = (win_shr[c] > (SW+1)'(MAX)) ? W'(MAX) : win_shr[c][W-1:0];
            avg_full[c] = sum_q[c] + AW'(win_res[c]);
            avg[c]      = W'(avg_full[c] >> L);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            delta_q <= '0;
            cnt_q   <= '0;
            osr_q   <= '0;
            frame_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                sigma_q[c] <= '0;
                sum_q[c]   <= '0;
            end
        end else begin
            delta_q <= analog_cmp;
            if (!enable) begin
                cnt_q   <= '0;
                frame_q <= '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    sigma_q[c] <= '0;
                    sum_q[c]   <= '0;
                end
            end else begin
                if (cnt_q == '0) osr_q <= osr_sel;
                if (win_end) begin
                    cnt_q   <= '0;
                    frame_q <= frame_q + 1'b1;
                    for (int c = 0; c < NUM_CH; c++) begin
                        sigma_q[c] <= '0;
                        sum_q[c]   <= frame_end ? '0 : avg_full[c];
                    end
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                    for (int c = 0; c < NUM_CH; c++) begin
                        sigma_q[c] <= sigma_q[c] + SW'(delta_q[c]);
                    end
                end
            end
        end
    end

    // A new bank always restarts at channel 0; it only counts as lost data when
    // entries remain unaccepted after this edge's handshake.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        overrun_d = overrun_q;
        hs        = (state_q == SEND) && dout_ready;
        last_hs   = hs && (ch_q == 3'(NUM_CH - 1));
        if (hs) begin
            if (last_hs) begin
                state_d = IDLE;
                ch_d    = '0;
            end else begin
                ch_d = ch_q + 3'd1;
            end
        end
        if (ovr_clr) overrun_d = 1'b0;
        if (frame_end) begin
            state_d = SEND;
            ch_d    = '0;
            if ((state_q == SEND) && !last_hs) overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            overrun_q <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) bank_q[c] <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            overrun_q <= overrun_d;
            if (frame_end) begin
                for (int c = 0; c < NUM_CH; c++) bank_q[c] <= avg[c];
            end
        end
    end

    always_comb begin
        dout_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_q == 3'(c)) dout_data = bank_q[c];
        end
    end

    assign dout_ch    = ch_q;
    assign dout_valid = (state_q == SEND);
    assign overrun    = overrun_q;
    assign analog_out = delta_q;

endmodule
